ocw2_priority_controller: RTL and testbench
===========================================

Name: ocw2_priority_controller

Overview:
- Clocked, parametrised successor to the combinational OCW2 decode in the 8259A control logic.
- Owns the in-service clear vector (EOI), auto-rotate mode and lowest-priority pointer for NUM_LEVELS interrupt levels.
- Registers all outputs and arbitrates OCW2 writes that collide with auto-EOI/auto-rotate at end of INTA through a one-entry hold slot.
- Sits between the bus/control-word decoder and the in-service/priority-resolver blocks.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels; power of two, 2..32.
- LEVEL_W, $clog2(NUM_LEVELS), level index width; localparam, not overridable.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- write_initial_command_word_1  input  1  ICW1 write strobe, one cycle
- auto_eoi_config  input  1  AEOI mode from ICW4
- end_of_acknowledge_sequence  input  1  final INTA cycle strobe
- acknowledge_interrupt  input  NUM_LEVELS  one-hot level being acknowledged
- write_operation_control_word_2  input  1  OCW2 write strobe, one cycle
- ocw2_command  input  3  {R,SL,EOI} field
- ocw2_level  input  LEVEL_W  L field
- highest_level_in_service  input  NUM_LEVELS  one-hot highest ISR bit, or zero
- end_of_interrupt  output  NUM_LEVELS  registered ISR-clear mask, one-cycle pulse
- auto_rotate_mode  output  1  registered
- priority_rotate  output  LEVEL_W  registered lowest-priority level
- command_error  output  1  one-cycle pulse
- hold_overflow  output  1  one-cycle pulse, OCW2 dropped

Behaviour:
- Reset values:
  - end_of_interrupt = 0, auto_rotate_mode = 0, priority_rotate = NUM_LEVELS-1.
  - command_error = 0, hold_overflow = 0, hold slot empty.
- All outputs are registered, with latency 1 from input strobe to output.
- end_of_interrupt, command_error and hold_overflow are zero in every cycle without an action.
- ICW1 (highest precedence):
  - Next cycle: end_of_interrupt = all ones, auto_rotate_mode = 0, priority_rotate = NUM_LEVELS-1.
  - Hold slot cleared; any coincident OCW2 or end_ack is ignored.
- Auto action, when end_of_acknowledge_sequence = 1:
  - If auto_eoi_config = 1: end_of_interrupt = acknowledge_interrupt.
  - If auto_rotate_mode = 1: priority_rotate = index of acknowledge_interrupt.
  - Both may apply in the same cycle.
  - A zero acknowledge_interrupt gives no EOI and no rotate.
- OCW2 command decode, applied in an execute cycle:
  - 001 non-specific EOI: eoi = highest_level_in_service.
  - 011 specific EOI: eoi = onehot(ocw2_level).
  - 101 rotate on non-specific EOI: eoi = highest_level_in_service, priority_rotate = index(highest).
  - 111 rotate on specific EOI: eoi = onehot(level), priority_rotate = level.
  - 110 set priority: priority_rotate = level.
  - 100: auto_rotate_mode = 1.
  - 000: auto_rotate_mode = 0.
  - 010: no-op, no error.
- Error cases:
  - 001 or 101 with highest_level_in_service = 0: no EOI, no rotate, command_error pulses.
  - highest_level_in_service is sampled in the execute cycle, not the write cycle.
- Hold-slot FSM, states IDLE and HELD:
  - IDLE: an OCW2 write without end_ack executes immediately.
  - IDLE: an OCW2 write with end_ack stores {command, level} and moves to HELD; the auto action executes.
  - HELD, no end_ack: the held command executes and the FSM returns to IDLE. A new OCW2 in that cycle is stored and the FSM stays HELD.
  - HELD with end_ack: the auto action executes and the held command waits. A new OCW2 in that cycle is dropped and hold_overflow pulses.
  - Auto-action priority_rotate wins over nothing: the held command never executes in the same cycle as an auto action.
- Reset mid-operation: the hold slot is discarded and all outputs return to reset values the next cycle.

Optional Feature:
- Macro OCW2_EOI_COUNT_EN.
- Defined:
  - Adds output port eoi_count, 16 bits, reset 0, cleared by ICW1.
  - Increments by 1 in each cycle where the registered end_of_interrupt is nonzero, excluding the ICW1 all-ones pulse.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ICW1 -> end_of_interrupt = 8'hFF for exactly one cycle, priority_rotate = 3'd7, auto_rotate_mode = 0.
- OCW2 3'b011, level 5 -> next cycle end_of_interrupt = 8'h20, then 8'h00; priority_rotate unchanged.
- OCW2 3'b100, then end_ack with acknowledge_interrupt = 8'h08 and auto_eoi_config = 1 -> end_of_interrupt = 8'h08, priority_rotate = 3'd3.
- OCW2 3'b111, level 2 written in the same cycle as end_ack (ack 8'h01, AEOI = 1) -> cycle+1 eoi = 8'h01; cycle+2 eoi = 8'h04, priority_rotate = 2.
- HELD state plus end_ack plus a second OCW2 -> hold_overflow pulses once; the first held command executes one cycle later; the second never executes.
- OCW2 3'b001 with highest_level_in_service = 0 -> command_error = 1 for one cycle, eoi = 0. With OCW2_EOI_COUNT_EN, eoi_count does not increment.

Source files
------------

// File: rtl/ocw2_priority_controller_if.sv
// Control-word bus between the OCW2 decoder side and ocw2_priority_controller.
// With OCW2_EOI_COUNT_EN defined, the interface also carries the eoi_count output.
interface ocw2_priority_controller_if #(
  parameter int NUM_LEVELS = 8
);
  localparam int LEVEL_W = $clog2(NUM_LEVELS);

  logic                  write_initial_command_word_1;
  logic                  auto_eoi_config;
  logic                  end_of_acknowledge_sequence;
  logic [NUM_LEVELS-1:0] acknowledge_interrupt;
  logic                  write_operation_control_word_2;
  logic [2:0]            ocw2_command;
  logic [LEVEL_W-1:0]    ocw2_level;
  logic [NUM_LEVELS-1:0] highest_level_in_service;
  logic [NUM_LEVELS-1:0] end_of_interrupt;
  logic                  auto_rotate_mode;
  logic [LEVEL_W-1:0]    priority_rotate;
  logic                  command_error;
  logic                  hold_overflow;
`ifdef OCW2_EOI_COUNT_EN
  logic [15:0]           eoi_count;
`endif

  modport master (
    output write_initial_command_word_1, auto_eoi_config, end_of_acknowledge_sequence,
           acknowledge_interrupt, write_operation_control_word_2, ocw2_command,
           ocw2_level, highest_level_in_service,
`ifdef OCW2_EOI_COUNT_EN
    input  eoi_count,
`endif
    input  end_of_interrupt, auto_rotate_mode, priority_rotate, command_error, hold_overflow
  );

  modport slave (
    input  write_initial_command_word_1, auto_eoi_config, end_of_acknowledge_sequence,
           acknowledge_interrupt, write_operation_control_word_2, ocw2_command,
           ocw2_level, highest_level_in_service,
`ifdef OCW2_EOI_COUNT_EN
    output eoi_count,
`endif
    output end_of_interrupt, auto_rotate_mode, priority_rotate, command_error, hold_overflow
  );
endinterface

// File: rtl/ocw2_priority_controller.sv
// Registered OCW2 EOI/rotate controller with a one-entry hold slot for OCW2 writes
// that collide with the end-of-INTA auto action. Optional macro: OCW2_EOI_COUNT_EN.
module ocw2_priority_controller #(
  parameter int NUM_LEVELS = 8
) (
  input logic                     clock,
  input logic                     reset,
  ocw2_priority_controller_if.slave bus
);
  localparam int LEVEL_W = $clog2(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  typedef struct packed {
    logic [2:0]         cmd;
    logic [LEVEL_W-1:0] lvl;
  } ocw2_req_t;

  function automatic logic [LEVEL_W-1:0] level_index(input logic [NUM_LEVELS-1:0] v);
    logic [LEVEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LEVELS; i++)
      if (v[i]) r = r | LEVEL_W'(i);
    return r;
  endfunction

  logic [0:0]            state_q, state_d;
  ocw2_req_t             hold_q, hold_d, exec_req, new_req;
  logic                  exec_en;
  logic [NUM_LEVELS-1:0] eoi_q, eoi_d;
  logic                  arm_q, arm_d;
  logic [LEVEL_W-1:0]    pr_q, pr_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;

  assign new_req = '{cmd: bus.ocw2_command, lvl: bus.ocw2_level};

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    exec_en  = 1'b0;
    exec_req = new_req;
    eoi_d    = '0;
    arm_d    = arm_q;
    pr_d     = pr_q;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    if (bus.write_initial_command_word_1) begin
      eoi_d   = '1;
      arm_d   = 1'b0;
      pr_d    = LAST_LEVEL;
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      // The held command only runs in a cycle with no auto action, so the two never race.
      case (state_q)
        IDLE: begin
          if (bus.write_operation_control_word_2) begin
            if (bus.end_of_acknowledge_sequence) begin
              hold_d  = new_req;
              state_d = HELD;
            end else begin
              exec_en = 1'b1;
            end
          end
        end
        default: begin
          if (bus.end_of_acknowledge_sequence) begin
            ovf_d = bus.write_operation_control_word_2;
          end else begin
            exec_en  = 1'b1;
            exec_req = hold_q;
            if (bus.write_operation_control_word_2) hold_d  = new_req;
            else                                    state_d = IDLE;
          end
        end
      endcase

      if (bus.end_of_acknowledge_sequence) begin
        if (bus.auto_eoi_config) eoi_d = bus.acknowledge_interrupt;
        if (arm_q && |bus.acknowledge_interrupt)
          pr_d = level_index(bus.acknowledge_interrupt);
      end

      if (exec_en) begin
        case (exec_req.cmd)
          3'b001: begin
            if (|bus.highest_level_in_service) eoi_d = bus.highest_level_in_service;
            else                               err_d = 1'b1;
          end
          3'b011: eoi_d[exec_req.lvl] = 1'b1;
          3'b101: begin
            if (|bus.highest_level_in_service) begin
              eoi_d = bus.highest_level_in_service;
              pr_d  = level_index(bus.highest_level_in_service);
            end else begin
              err_d = 1'b1;
            end
          end
          3'b111: begin
            eoi_d[exec_req.lvl] = 1'b1;
            pr_d                = exec_req.lvl;
          end
          3'b110:  pr_d  = exec_req.lvl;
          3'b100:  arm_d = 1'b1;
          3'b000:  arm_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      eoi_q   <= '0;
      arm_q   <= 1'b0;
      pr_q    <= LAST_LEVEL;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      eoi_q   <= eoi_d;
      arm_q   <= arm_d;
      pr_q    <= pr_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.end_of_interrupt = eoi_q;
  assign bus.auto_rotate_mode = arm_q;
  assign bus.priority_rotate  = pr_q;
  assign bus.command_error    = err_q;
  assign bus.hold_overflow    = ovf_q;

`ifdef OCW2_EOI_COUNT_EN
  logic [15:0] cnt_q;
  logic        icw1_pulse_q;  // marks eoi_q as the ICW1 all-ones clear, which is not counted

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      icw1_pulse_q <= 1'b0;
    end else begin
      icw1_pulse_q <= bus.write_initial_command_word_1;
      if (bus.write_initial_command_word_1)
        cnt_q <= '0;
      else if (|eoi_q && !icw1_pulse_q && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.eoi_count = cnt_q;
`endif
endmodule

// File: tb/tb_ocw2_priority_controller.sv
// Table-driven directed bench for ocw2_priority_controller (NUM_LEVELS = 8).
// Each row is one clock of stimulus plus the registered outputs expected after that edge.
module tb_ocw2_priority_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ocw2_priority_controller_if #(.NUM_LEVELS(8)) bus_if ();
  ocw2_priority_controller #(.NUM_LEVELS(8)) dut (.clock(clock), .reset(reset), .bus(bus_if));

  typedef struct {
    logic       icw1, aeoi, ea;
    logic [7:0] ack;
    logic       wr;
    logic [2:0] cmd, lvl;
    logic [7:0] hisr;
    logic [7:0] eoi;
    logic       arm;
    logic [2:0] pr;
    logic       err, ovf;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic prev_eoi_nz = 1'b0, prev_icw1 = 1'b0;

  function automatic vec_t mk(logic icw1, logic aeoi, logic ea, logic [7:0] ack,
                              logic wr, logic [2:0] cmd, logic [2:0] lvl, logic [7:0] hisr,
                              logic [7:0] eoi, logic arm, logic [2:0] pr, logic err, logic ovf);
    vec_t v;
    v.icw1 = icw1; v.aeoi = aeoi; v.ea = ea; v.ack = ack; v.wr = wr; v.cmd = cmd;
    v.lvl = lvl; v.hisr = hisr; v.eoi = eoi; v.arm = arm; v.pr = pr; v.err = err; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.write_initial_command_word_1   = v.icw1;
    bus_if.auto_eoi_config                = v.aeoi;
    bus_if.end_of_acknowledge_sequence    = v.ea;
    bus_if.acknowledge_interrupt          = v.ack;
    bus_if.write_operation_control_word_2 = v.wr;
    bus_if.ocw2_command                   = v.cmd;
    bus_if.ocw2_level                     = v.lvl;
    bus_if.highest_level_in_service       = v.hisr;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " eoi"}, 32'(bus_if.end_of_interrupt), 32'(v.eoi));
    chk({tag, " arm"}, 32'(bus_if.auto_rotate_mode), 32'(v.arm));
    chk({tag, " pr"},  32'(bus_if.priority_rotate),  32'(v.pr));
    chk({tag, " err"}, 32'(bus_if.command_error),    32'(v.err));
    chk({tag, " ovf"}, 32'(bus_if.hold_overflow),    32'(v.ovf));
`ifdef OCW2_EOI_COUNT_EN
    chk({tag, " cnt"}, 32'(bus_if.eoi_count), 32'(exp_cnt));
`endif
  endtask

  task automatic step(input string tag, input vec_t v);
    drive(v);
    @(posedge clock);
    #1;
    // Counter trails the registered EOI by one cycle and ignores the ICW1 pulse.
    if (v.icw1) exp_cnt = 0;
    else if (prev_eoi_nz && !prev_icw1 && exp_cnt != 65535) exp_cnt++;
    check_outs(tag, v);
    prev_eoi_nz = |v.eoi;
    prev_icw1   = v.icw1;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    //            icw1 aeoi ea ack    wr cmd     lvl  hisr  | eoi   arm pr err ovf
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'hFF, 0, 3'd7, 0, 0)); // 0 ICW1
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b011, 3'd5, 8'h00, 8'h20, 0, 3'd7, 0, 0)); // specific EOI 5
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b100, 3'd0, 8'h00, 8'h00, 1, 3'd7, 0, 0)); // auto-rotate on
    tbl.push_back(mk(0, 1, 1, 8'h08, 0, 3'b000, 3'd0, 8'h00, 8'h08, 1, 3'd3, 0, 0)); // AEOI + rotate
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 1, 3'd3, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h01, 1, 3'b111, 3'd2, 8'h00, 8'h01, 1, 3'd0, 0, 0)); // collide -> HELD
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h04, 1, 3'd2, 0, 0)); // held 111 lvl2
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 1, 3'd2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h02, 1, 3'b011, 3'd6, 8'h00, 8'h00, 1, 3'd1, 0, 0)); // HELD 011 lvl6
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 3'b111, 3'd3, 8'h00, 8'h00, 1, 3'd1, 0, 1)); // overflow
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h40, 1, 3'd1, 0, 0)); // first runs
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 1, 3'd1, 0, 0)); // second never
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b001, 3'd0, 8'h00, 8'h00, 1, 3'd1, 1, 0)); // NS-EOI, no ISR
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 1, 3'd1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b001, 3'd0, 8'h10, 8'h10, 1, 3'd1, 0, 0)); // NS-EOI
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b101, 3'd0, 8'h04, 8'h04, 1, 3'd2, 0, 0)); // rot NS-EOI
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b101, 3'd0, 8'h00, 8'h00, 1, 3'd2, 1, 0)); // rot NS, no ISR
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b110, 3'd6, 8'h00, 8'h00, 1, 3'd6, 0, 0)); // set priority
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd6, 0, 0)); // auto-rotate off
    tbl.push_back(mk(0, 0, 1, 8'h20, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd6, 0, 0)); // no AEOI/rotate
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b010, 3'd4, 8'h00, 8'h00, 0, 3'd6, 0, 0)); // no-op
    tbl.push_back(mk(0, 1, 1, 8'h80, 1, 3'b011, 3'd0, 8'h00, 8'h80, 0, 3'd6, 0, 0)); // HELD 011 lvl0
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'b011, 3'd1, 8'h00, 8'h01, 0, 3'd6, 0, 0)); // run + re-store
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h02, 0, 3'd6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd6, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 1, 3'b001, 3'd0, 8'h01, 8'h00, 0, 3'd6, 0, 0)); // zero ack, HELD
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h08, 8'h08, 0, 3'd6, 0, 0)); // ISR at execute
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 3'b101, 3'd0, 8'h02, 8'h00, 0, 3'd6, 0, 0)); // HELD 101
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd6, 1, 0)); // err at execute
    tbl.push_back(mk(1, 1, 1, 8'h04, 1, 3'b110, 3'd2, 8'h00, 8'hFF, 0, 3'd7, 0, 0)); // ICW1 wins
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 3'b011, 3'd3, 8'h00, 8'h00, 0, 3'd7, 0, 0)); // HELD 011 lvl3
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'hFF, 0, 3'd7, 0, 0)); // ICW1 drops hold
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd7, 0, 0));

    idle = mk(0, 0, 0, 8'h00, 0, 3'b000, 3'd0, 8'h00, 8'h00, 0, 3'd7, 0, 0);
    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", idle);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i]);

    // Reset in the middle of a held command discards it and restores reset values.
    step("mid arm", mk(0, 0, 0, 8'h00, 1, 3'b100, 3'd0, 8'h00, 8'h00, 1, 3'd7, 0, 0));
    step("mid pr",  mk(0, 0, 0, 8'h00, 1, 3'b110, 3'd4, 8'h00, 8'h00, 1, 3'd4, 0, 0));
    step("mid hold", mk(0, 0, 1, 8'h00, 1, 3'b011, 3'd5, 8'h00, 8'h00, 1, 3'd4, 0, 0));
    drive(idle);
    reset = 1'b1;
    @(posedge clock);
    #1;
    exp_cnt = 0;
    prev_eoi_nz = 1'b0;
    prev_icw1   = 1'b0;
    check_outs("mid reset", idle);
    reset = 1'b0;
    step("post reset", idle);
    step("post reset2", idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
